// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - shared state encoding and instruction field helpers for exec_sequencer
package exec_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC1  = 3'd3,
      ST_EXT    = 3'd4
   } state_e;

   // Instruction class field: 2'b11 is executed by the ALU, anything else is external.
   localparam int           CODE_MSB = 15;
   localparam int           CODE_LSB = 14;
   localparam logic [1:0]   CODE_ARM = 2'b11;

   function automatic logic [1:0] instr_code(input logic [15:0] word);
      return word[CODE_MSB:CODE_LSB];
   endfunction

   function automatic logic is_arm(input logic [15:0] word);
      return instr_code(word) == CODE_ARM;
   endfunction

endpackage

// File: rtl/exec_sequencer_flags.sv
// rtl/exec_sequencer_flags.sv - CARRY and SKIP flip-flops with enables and squash clear
module seq_flags (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic exec1_i,
   input  logic squash_i,
   input  logic carry_i,
   input  logic carry_en_i,
   input  logic skip_i,
   input  logic skip_en_i,
   output logic carry_o,
   output logic skip_o
);

   logic carry_q, carry_d;
   logic skip_q, skip_d;

   // Flags only move on the EXEC1 edge (ALU enables) or when a skipped word is squashed.
   always_comb begin
      carry_d = carry_q;
      skip_d  = skip_q;
      if (exec1_i && carry_en_i) begin
         carry_d = carry_i;
      end
      if (squash_i) begin
         skip_d = 1'b0;
      end else if (exec1_i && skip_en_i) begin
         skip_d = skip_i;
      end
   end

   // Flag storage, cleared by reset so an aborted instruction leaves no trace.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         carry_q <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         carry_q <= carry_d;
         skip_q  <= skip_d;
      end
   end

   assign carry_o = carry_q;
   assign skip_o  = skip_q;

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - fetch/execute controller ahead of the ALU; optional SEQ_SINGLE_STEP_EN gates fetches on step edges
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int                    PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
   input  logic                clk,
   input  logic                resetn,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [15:0]         imem_rdata,
   output logic [15:0]         instr,
   output logic                exec1,
   output logic                carrystatus,
   output logic                skipstatus,
   input  logic                carryin,
   input  logic                carryen,
   input  logic                skipin,
   input  logic                skipen,
   output logic                ext_start,
   input  logic                ext_done,
   input  logic                ext_pc_load,
   input  logic [PC_WIDTH-1:0] ext_pc,
   input  logic                step
);

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

`ifdef SEQ_SINGLE_STEP_EN
   // Entering FETCH waits for a captured step edge before requesting.
   localparam logic REQ_ON_ENTRY = 1'b0;
   logic step_q;
   logic step_pend_q;
`else
   localparam logic REQ_ON_ENTRY = 1'b1;
   logic unused_step;
   assign unused_step = step;
`endif

   state_e              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [15:0]         instr_q;
   logic                imem_req_q;
   logic                exec1_q;
   logic                ext_start_q;
   logic                squash;

   // A DECODE cycle with SKIP set throws the fetched word away and clears SKIP.
   assign squash = (state_q == ST_DECODE) && skipstatus;

   seq_flags u_flags (
      .clk_i      (clk),
      .rst_ni     (resetn),
      .exec1_i    (exec1_q),
      .squash_i   (squash),
      .carry_i    (carryin),
      .carry_en_i (carryen),
      .skip_i     (skipin),
      .skip_en_i  (skipen),
      .carry_o    (carrystatus),
      .skip_o     (skipstatus)
   );

   // Sequencer FSM; exec1 and ext_start are registered so they are glitch-free one-cycle pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_RST;
         pc_q        <= RESET_PC;
         instr_q     <= 16'h0000;
         imem_req_q  <= 1'b0;
         exec1_q     <= 1'b0;
         ext_start_q <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
         step_q      <= 1'b0;
         step_pend_q <= 1'b0;
`endif
      end else begin
         exec1_q     <= 1'b0;
         ext_start_q <= 1'b0;
         case (state_q)
            ST_RST: begin
               state_q    <= ST_FETCH;
               imem_req_q <= REQ_ON_ENTRY;
            end
            ST_FETCH: begin
               if (imem_req_q && imem_ack) begin
                  instr_q    <= imem_rdata;
                  pc_q       <= pc_q + PC_ONE;
                  imem_req_q <= 1'b0;
                  state_q    <= ST_DECODE;
                  // SKIP cannot change during FETCH, so the hand-off pulse can be
                  // decided here and land exactly on the DECODE cycle.
                  ext_start_q <= !skipstatus && !is_arm(imem_rdata);
               end
`ifdef SEQ_SINGLE_STEP_EN
               else if (!imem_req_q && step_pend_q) begin
                  imem_req_q  <= 1'b1;
                  step_pend_q <= 1'b0;
               end
`endif
            end
            ST_DECODE: begin
               if (skipstatus) begin
                  state_q    <= ST_FETCH;
                  imem_req_q <= REQ_ON_ENTRY;
               end else if (is_arm(instr_q)) begin
                  state_q <= ST_EXEC1;
                  exec1_q <= 1'b1;
               end else begin
                  state_q <= ST_EXT;
               end
            end
            ST_EXEC1: begin
               state_q    <= ST_FETCH;
               imem_req_q <= REQ_ON_ENTRY;
            end
            ST_EXT: begin
               if (ext_done) begin
                  if (ext_pc_load) begin
                     pc_q <= ext_pc;
                  end
                  state_q    <= ST_FETCH;
                  imem_req_q <= REQ_ON_ENTRY;
               end
            end
            default: begin
               state_q    <= ST_RST;
               imem_req_q <= 1'b0;
            end
         endcase
`ifdef SEQ_SINGLE_STEP_EN
         // Placed after the FSM so an edge arriving as a request issues is not lost.
         step_q <= step;
         if (step && !step_q) begin
            step_pend_q <= 1'b1;
         end
`endif
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign exec1     = exec1_q;
   assign ext_start = ext_start_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard bench for exec_sequencer
module tb_exec_sequencer;

   localparam int K_FETCH = 0;
   localparam int K_EXEC  = 1;
   localparam int K_EXT   = 2;

   typedef struct {
      int          kind;
      logic [15:0] val;
      logic        c;
      logic        s;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic [15:0] instr;
   logic        exec1;
   logic        carrystatus;
   logic        skipstatus;
   logic        carryin = 1'b0;
   logic        carryen = 1'b0;
   logic        skipin = 1'b0;
   logic        skipen = 1'b0;
   logic        ext_start;
   logic        ext_done = 1'b0;
   logic        ext_pc_load = 1'b0;
   logic [15:0] ext_pc = 16'h0000;
   logic        step = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   logic [15:0] pc_m = 16'h0000;
   logic        carry_m = 1'b0;
   logic        skip_m = 1'b0;

   always #5 clk = ~clk;

   exec_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .exec1       (exec1),
      .carrystatus (carrystatus),
      .skipstatus  (skipstatus),
      .carryin     (carryin),
      .carryen     (carryen),
      .skipin      (skipin),
      .skipen      (skipen),
      .ext_start   (ext_start),
      .ext_done    (ext_done),
      .ext_pc_load (ext_pc_load),
      .ext_pc      (ext_pc),
      .step        (step)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [15:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.c    = carry_m;
      e.s    = skip_m;
      sb.push_back(e);
   endtask

   task automatic ev(input int kind, input logic [15:0] val);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_event: got kind %0d value %h, expected no event", kind, val);
      end else begin
         e = sb.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_value", val, e.val);
         chk("event_carrystatus", carrystatus, e.c);
         chk("event_skipstatus", skipstatus, e.s);
      end
   endtask

   // Monitor: samples on the falling edge, pops one expectation per DUT event.
   always @(negedge clk) begin
      if (resetn) begin
         if (imem_req && imem_ack) ev(K_FETCH, imem_addr);
         if (exec1)                ev(K_EXEC, instr);
         if (ext_start)            ev(K_EXT, instr);
      end
   end

   task automatic do_fetch(input logic [15:0] word, input int delay,
                           input logic cin, input logic cen, input logic sin, input logic sen);
      int n = 0;
      while (!imem_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_seen", imem_req, 1'b1);
      if (!imem_req) return;
      for (int d = 0; d < delay; d++) begin
         chk("req_held", imem_req, 1'b1);
         chk("addr_stable", imem_addr, pc_m);
         @(posedge clk); #1;
      end
      push(K_FETCH, pc_m);
      pc_m = pc_m + 16'h0001;
      if (skip_m) begin
         skip_m = 1'b0;
      end else if (word[15:14] == 2'b11) begin
         push(K_EXEC, word);
         if (cen) carry_m = cin;
         if (sen) skip_m = sin;
      end else begin
         push(K_EXT, word);
      end
      carryin = cin; carryen = cen; skipin = sin; skipen = sen;
      imem_rdata = word;
      imem_ack = 1'b1;
      @(posedge clk); #1;
      imem_ack = 1'b0;
   endtask

   task automatic do_ext(input logic load, input logic [15:0] target, input int wait_cycles);
      for (int i = 0; i < wait_cycles; i++) begin
         @(posedge clk); #1;
      end
      ext_done = 1'b1;
      ext_pc_load = load;
      ext_pc = target;
      @(posedge clk); #1;
      ext_done = 1'b0;
      ext_pc_load = 1'b0;
      if (load) pc_m = target;
   endtask

   task automatic chk_reset();
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_exec1", exec1, 1'b0);
      chk("rst_ext_start", ext_start, 1'b0);
      chk("rst_carry", carrystatus, 1'b0);
      chk("rst_skip", skipstatus, 1'b0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      pc_m = 16'h0000;
      carry_m = 1'b0;
      skip_m = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      release_reset();

      // ARM word, ack in same cycle as request: exec1 in third cycle, then CARRY set
      do_fetch(16'hC000, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("exec1_in_decode", exec1, 1'b0);
      @(posedge clk); #1;
      chk("exec1_third_cycle", exec1, 1'b1);
      chk("pc_after_first", imem_addr, 16'h0001);
      @(posedge clk); #1;
      chk("carry_set", carrystatus, 1'b1);

      // carryen low: CARRY holds
      do_fetch(16'hC001, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      // clear CARRY, set SKIP
      do_fetch(16'hC002, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      // this word is squashed
      do_fetch(16'hC123, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      // external instruction with jump after 5 cycles
      do_fetch(16'h4123, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_ext(1'b1, 16'h0040, 5);
      // delayed ack at the jump target
      do_fetch(16'hC000, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      // jump to the top of the address space, then wrap
      do_fetch(16'h8000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_ext(1'b1, 16'hFFFF, 2);
      do_fetch(16'hC000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_fetch(16'hC000, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      // external without PC load
      do_fetch(16'h0001, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_ext(1'b0, 16'h1234, 3);

      // reset during EXEC1 of an instruction that would set CARRY
      do_fetch(16'hC000, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); #1;
      resetn = 1'b0;
      #1;
      chk_reset();
      carry_m = 1'b0;
      release_reset();
      do_fetch(16'hC000, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset while waiting in EXT
      do_fetch(16'h4000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      resetn = 1'b0;
      #1;
      chk_reset();
      release_reset();
      do_fetch(16'hC000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
